// File: rtl/serial_paralelo_rx_if.sv
// Serial receive lane bundle: 1-bit stream in, aligned byte and lane status out.
interface serial_paralelo_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: bit-hunts for COM, locks after BC_COUNT aligned
// COM bytes, then presents each received byte with a valid for non-COM data.
module serial_paralelo_rx #(
    parameter int         BC_COUNT = 4,
    parameter logic [7:0] COM      = 8'hBC
) (
    input  logic          clk_32f,
    input  logic          reset,
    serial_paralelo_rx_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] BC_N = 4'(BC_COUNT);

    state_t     r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_bc_cnt;
    logic [7:0] r_data_out;
    logic       r_valid;
    logic       r_active;

    state_t     w_state_nxt;
    logic [2:0] w_bit_nxt;
    logic [3:0] w_bc_nxt;
    logic [7:0] w_data_nxt;
    logic       w_valid_nxt;
    logic       w_active_nxt;
    logic [7:0] w_byte;
    logic [3:0] w_bc_inc;
    logic       w_is_com;
    logic       w_boundary;

    assign w_byte     = {r_sr[6:0], bus.data_in};
    assign w_bc_inc   = r_bc_cnt + 4'd1;
    assign w_is_com   = (w_byte == COM);
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_nxt  = r_state;
        w_bit_nxt    = r_bit_cnt;
        w_bc_nxt     = r_bc_cnt;
        w_data_nxt   = r_data_out;
        w_valid_nxt  = r_valid;
        w_active_nxt = r_active;
        unique case (r_state)
            SEARCH: begin
                if (w_is_com) begin
                    w_bit_nxt = 3'd0;
                    w_bc_nxt  = 4'd1;
                    if (BC_N == 4'd1) begin
                        w_state_nxt  = ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ALIGN;
                    end
                end
            end
            ALIGN: begin
                w_bit_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_bc_nxt = w_bc_inc;
                        if (w_bc_inc == BC_N) begin
                            w_state_nxt  = ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        // failed byte earns nothing; hunt resumes next edge
                        w_bc_nxt    = 4'd0;
                        w_state_nxt = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                w_bit_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    w_data_nxt  = w_byte;
                    w_valid_nxt = !w_is_com;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state    <= SEARCH;
            r_sr       <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_bc_cnt   <= 4'd0;
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_byte;
            r_bit_cnt  <= w_bit_nxt;
            r_bc_cnt   <= w_bc_nxt;
            r_data_out <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_active   <= w_active_nxt;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid;
    assign bus.active    = r_active;

endmodule
